// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin time-sharing of one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to enable the per-requester accepted-operation counters.
module alu_share_arbiter #(
    parameter int unsigned SIZEDATA = 8,
    parameter int unsigned SIZEOP   = 6,
    parameter int unsigned CNTW     = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req0_valid,
    input  logic [SIZEDATA-1:0] i_req0_a,
    input  logic [SIZEDATA-1:0] i_req0_b,
    input  logic [SIZEOP-1:0]   i_req0_op,
    output logic                o_req0_ready,
    input  logic                i_req1_valid,
    input  logic [SIZEDATA-1:0] i_req1_a,
    input  logic [SIZEDATA-1:0] i_req1_b,
    input  logic [SIZEOP-1:0]   i_req1_op,
    output logic                o_req1_ready,
    output logic                o_rsp0_valid,
    output logic                o_rsp1_valid,
    output logic [SIZEDATA-1:0] o_rsp_result,
    input  logic                i_rsp0_ready,
    input  logic                i_rsp1_ready,
    output logic [SIZEDATA-1:0] o_alu_datoa,
    output logic [SIZEDATA-1:0] o_alu_datob,
    output logic [SIZEOP-1:0]   o_alu_opcode,
    input  logic [SIZEDATA-1:0] i_alu_result,
    output logic                o_busy,
    output logic [CNTW-1:0]     o_grant_cnt0,
    output logic [CNTW-1:0]     o_grant_cnt1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [SIZEDATA-1:0] r_a;
    logic [SIZEDATA-1:0] r_b;
    logic [SIZEOP-1:0]   r_op;
    logic [SIZEDATA-1:0] r_result;
    logic                r_gid;
    logic                r_ptr;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic                w_idle;
    logic                w_gnt1;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_rsp_hs;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        w_idle   = (r_state == ST_IDLE) & ~i_reset;
        w_gnt1   = (i_req0_valid & i_req1_valid) ? r_ptr : i_req1_valid;
        w_acc0   = w_idle & i_req0_valid & ~w_gnt1;
        w_acc1   = w_idle & i_req1_valid & w_gnt1;
        w_rsp_hs = (r_state == ST_RESP) & (r_gid ? i_rsp1_ready : i_rsp0_ready);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc0 | w_acc1) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, result capture and response/pointer bookkeeping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_gid        <= 1'b0;
            r_ptr        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            if (w_acc0 | w_acc1) begin
                r_a   <= w_acc1 ? i_req1_a  : i_req0_a;
                r_b   <= w_acc1 ? i_req1_b  : i_req0_b;
                r_op  <= w_acc1 ? i_req1_op : i_req0_op;
                r_gid <= w_acc1;
            end
            if (r_state == ST_EXEC) begin
                r_result     <= i_alu_result;
                r_rsp0_valid <= ~r_gid;
                r_rsp1_valid <= r_gid;
            end
            if (w_rsp_hs) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
                r_ptr        <= ~r_gid;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNTW-1:0] r_cnt0;
    logic [CNTW-1:0] r_cnt1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc0) r_cnt0 <= r_cnt0 + CNTW'(1);
            if (w_acc1) r_cnt1 <= r_cnt1 + CNTW'(1);
        end
    end

    assign o_grant_cnt0 = r_cnt0;
    assign o_grant_cnt1 = r_cnt1;
`else
    assign o_grant_cnt0 = '0;
    assign o_grant_cnt1 = '0;
`endif

    assign o_req0_ready = w_acc0;
    assign o_req1_ready = w_acc1;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp_result = r_result;
    assign o_alu_datoa  = r_a;
    assign o_alu_datob  = r_b;
    assign o_alu_opcode = r_op;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter with a small ALU model.
module tb_alu_share_arbiter;

    localparam int unsigned SIZEDATA = 8;
    localparam int unsigned SIZEOP   = 6;
    localparam int unsigned CNTW     = 16;

    localparam logic [5:0] OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic                i_clk;
    logic                i_reset;
    logic                i_req0_valid, i_req1_valid;
    logic [SIZEDATA-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [SIZEOP-1:0]   i_req0_op, i_req1_op;
    logic                o_req0_ready, o_req1_ready;
    logic                o_rsp0_valid, o_rsp1_valid;
    logic [SIZEDATA-1:0] o_rsp_result;
    logic                i_rsp0_ready, i_rsp1_ready;
    logic [SIZEDATA-1:0] o_alu_datoa, o_alu_datob;
    logic [SIZEOP-1:0]   o_alu_opcode;
    logic [SIZEDATA-1:0] alu_res;
    logic                o_busy;
    logic [CNTW-1:0]     o_grant_cnt0, o_grant_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.SIZEDATA(SIZEDATA), .SIZEOP(SIZEOP), .CNTW(CNTW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req0_op(i_req0_op), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .i_req1_op(i_req1_op), .o_req1_ready(o_req1_ready),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
        .o_rsp_result(o_rsp_result),
        .i_rsp0_ready(i_rsp0_ready), .i_rsp1_ready(i_rsp1_ready),
        .o_alu_datoa(o_alu_datoa), .o_alu_datob(o_alu_datob),
        .o_alu_opcode(o_alu_opcode), .i_alu_result(alu_res),
        .o_busy(o_busy), .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Minimal ALU: the opcodes exercised here, everything else reads 0.
    always_comb begin
        alu_res = '0;
        case (o_alu_opcode)
            OP_ADDU: alu_res = o_alu_datoa + o_alu_datob;
            OP_SUBU: alu_res = o_alu_datoa - o_alu_datob;
            OP_OR:   alu_res = o_alu_datoa | o_alu_datob;
            OP_SLL:  alu_res = o_alu_datoa << o_alu_datob;
            OP_SLT:  alu_res = 8'($signed(o_alu_datoa) < $signed(o_alu_datob));
            default: alu_res = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        i_req0_valid = v; i_req0_a = a; i_req0_b = b; i_req0_op = op;
    endtask

    task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        i_req1_valid = v; i_req1_a = a; i_req1_b = b; i_req1_op = op;
    endtask

    // One full IDLE->EXEC->RESP->IDLE pass; requires the granted rsp_ready to be high.
    task automatic op_cycle(input string tag, input int gnt, input logic [7:0] res);
        @(negedge i_clk);
        check_eq({tag, "_rdy0"}, 32'(o_req0_ready), 32'(gnt == 0));
        check_eq({tag, "_rdy1"}, 32'(o_req1_ready), 32'(gnt == 1));
        step();
        @(negedge i_clk);
        check_eq({tag, "_busy_exec"}, 32'(o_busy), 32'd1);
        check_eq({tag, "_rspv_exec"}, 32'({o_rsp1_valid, o_rsp0_valid}), 32'd0);
        step();
        @(negedge i_clk);
        check_eq({tag, "_rsp0v"}, 32'(o_rsp0_valid), 32'(gnt == 0));
        check_eq({tag, "_rsp1v"}, 32'(o_rsp1_valid), 32'(gnt == 1));
        check_eq({tag, "_result"}, 32'(o_rsp_result), 32'(res));
        step();
    endtask

    initial begin
        i_reset = 1'b1;
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);
        i_rsp0_ready = 1'b0;
        i_rsp1_ready = 1'b0;

        @(negedge i_clk);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_rspv", 32'({o_rsp1_valid, o_rsp0_valid}), 32'd0);
        check_eq("rst_result", 32'(o_rsp_result), 32'd0);
        check_eq("rst_alu_a", 32'(o_alu_datoa), 32'd0);
        check_eq("rst_cnt", 32'({o_grant_cnt1, o_grant_cnt0}), 32'd0);
        step();
        i_reset = 1'b0;

        // Single op: ADDU 5+3 from req0.
        set_req0(1'b1, 8'd5, 8'd3, OP_ADDU);
        @(negedge i_clk);
        check_eq("single_rdy0", 32'(o_req0_ready), 32'd1);
        check_eq("single_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        @(negedge i_clk);
        check_eq("single_busy", 32'(o_busy), 32'd1);
        check_eq("single_rsp0v_exec", 32'(o_rsp0_valid), 32'd0);
        check_eq("single_alu_a", 32'(o_alu_datoa), 32'd5);
        check_eq("single_alu_op", 32'(o_alu_opcode), 32'(OP_ADDU));
        step();
        @(negedge i_clk);
        check_eq("single_rsp0v", 32'(o_rsp0_valid), 32'd1);
        check_eq("single_rsp1v", 32'(o_rsp1_valid), 32'd0);
        check_eq("single_result", 32'(o_rsp_result), 32'd8);
        i_rsp0_ready = 1'b1;
        step();
        i_rsp0_ready = 1'b0;
        @(negedge i_clk);
        check_eq("single_done_rsp0v", 32'(o_rsp0_valid), 32'd0);
        check_eq("single_done_busy", 32'(o_busy), 32'd0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        set_req0(1'b1, 8'd9, 8'd4, OP_SUBU);
        set_req1(1'b1, 8'h0C, 8'h03, OP_OR);
        op_cycle("rr0", 0, 8'd5);
        op_cycle("rr1", 1, 8'h0F);
        op_cycle("rr2", 0, 8'd5);
        op_cycle("rr3", 1, 8'h0F);
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);

        // Backpressure on rsp1 while req0 waits; rsp0_ready must be ignored.
        i_rsp0_ready = 1'b0;
        i_rsp1_ready = 1'b0;
        set_req1(1'b1, 8'd2, 8'd2, OP_ADDU);
        step();
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);
        set_req0(1'b1, 8'd10, 8'd20, OP_ADDU);
        step();
        i_rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check_eq("bp_rsp1v", 32'(o_rsp1_valid), 32'd1);
            check_eq("bp_result", 32'(o_rsp_result), 32'd4);
            check_eq("bp_busy", 32'(o_busy), 32'd1);
            check_eq("bp_rdy0", 32'(o_req0_ready), 32'd0);
            step();
        end
        i_rsp1_ready = 1'b1;
        @(negedge i_clk);
        check_eq("bp_rel_rdy0", 32'(o_req0_ready), 32'd0);
        step();
        i_rsp1_ready = 1'b0;
        @(negedge i_clk);
        check_eq("bp_after_rsp1v", 32'(o_rsp1_valid), 32'd0);
        check_eq("bp_after_rdy0", 32'(o_req0_ready), 32'd1);
        step();
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        step();
        @(negedge i_clk);
        check_eq("bp_req0_rsp0v", 32'(o_rsp0_valid), 32'd1);
        check_eq("bp_req0_result", 32'(o_rsp_result), 32'd30);
        step();

        // Shift, signed compare and unsupported opcode via req1.
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        set_req1(1'b1, 8'd1, 8'd3, OP_SLL);
        op_cycle("sll", 1, 8'd8);
        set_req1(1'b1, 8'hFE, 8'd1, OP_SLT);
        op_cycle("slt", 1, 8'd1);
        set_req1(1'b1, 8'hA5, 8'h5A, OP_BAD);
        op_cycle("badop", 1, 8'd0);
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);

        // Reset during EXEC with the pointer favouring req1.
        set_req0(1'b1, 8'd1, 8'd1, OP_ADDU);
        op_cycle("pre_rst", 0, 8'd2);
        set_req0(1'b1, 8'd5, 8'd3, OP_ADDU);
        set_req1(1'b1, 8'h0C, 8'h03, OP_OR);
        @(negedge i_clk);
        check_eq("mid_rdy1", 32'(o_req1_ready), 32'd1);
        step();
        set_req0(1'b0, 8'd5, 8'd3, OP_ADDU);
        set_req1(1'b0, 8'h0C, 8'h03, OP_OR);
        @(negedge i_clk);
        check_eq("mid_busy_exec", 32'(o_busy), 32'd1);
        #1 i_reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_rspv", 32'({o_rsp1_valid, o_rsp0_valid}), 32'd0);
        check_eq("mid_rst_rdy", 32'({o_req1_ready, o_req0_ready}), 32'd0);
        step();
        step();
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_eq("mid_no_stale_rsp", 32'({o_rsp1_valid, o_rsp0_valid}), 32'd0);
            step();
        end
        set_req0(1'b1, 8'd5, 8'd3, OP_ADDU);
        set_req1(1'b1, 8'h0C, 8'h03, OP_OR);
        op_cycle("post_rst", 0, 8'd8);
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);

        // Grant counters: 3 req0 ops and 2 req1 ops after a clean reset.
        do_reset();
        set_req0(1'b1, 8'd1, 8'd2, OP_ADDU);
        op_cycle("st0a", 0, 8'd3);
        set_req0(1'b1, 8'd7, 8'd2, OP_SUBU);
        op_cycle("st0b", 0, 8'd5);
        set_req0(1'b1, 8'hF0, 8'h0F, OP_OR);
        op_cycle("st0c", 0, 8'hFF);
        set_req0(1'b0, 8'd0, 8'd0, 6'd0);
        set_req1(1'b1, 8'd3, 8'd2, OP_SLL);
        op_cycle("st1a", 1, 8'd12);
        set_req1(1'b1, 8'd1, 8'hFF, OP_SLT);
        op_cycle("st1b", 1, 8'd0);
        set_req1(1'b0, 8'd0, 8'd0, 6'd0);
        @(negedge i_clk);
`ifdef ALU_ARB_STATS_EN
        check_eq("cnt0", 32'(o_grant_cnt0), 32'd3);
        check_eq("cnt1", 32'(o_grant_cnt1), 32'd2);
`else
        check_eq("cnt0", 32'(o_grant_cnt0), 32'd0);
        check_eq("cnt1", 32'(o_grant_cnt1), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
